// File: rtl/banked_vector_ram_if.sv
// Request/response bundle for banked_vector_ram: one vector request in, one
// lane-ordered response vector out, each with a valid/ready handshake.
interface banked_vector_ram_if #(
    parameter int PORTS      = 8,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic                          req_valid;
    logic                          req_ready;
    logic                          req_write;
    logic [PORTS-1:0]              req_mask;
    logic [PORTS*ADDR_WIDTH-1:0]   req_addr;
    logic [PORTS*DATA_WIDTH-1:0]   req_wdata;
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [PORTS*DATA_WIDTH-1:0]   rsp_rdata;
    logic [PORTS-1:0]              rsp_err;

    modport master (
        output req_valid, req_write, req_mask, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_mask, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/banked_vector_ram.sv
// Multi-bank vector RAM with per-bank round-robin conflict serialisation.
// Optional counters enabled by defining BANKED_VRAM_STATS_EN.
module banked_vector_ram #(
    parameter int PORTS         = 8,
    parameter int NUM_BANKS     = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 16,
    parameter int VECTOR_LENGTH = 64
) (
    input  logic clk,
    input  logic rst_n,
    banked_vector_ram_if.slave bus
`ifdef BANKED_VRAM_STATS_EN
    ,
    output logic [31:0] stat_conflict_cycles,
    output logic [31:0] stat_requests
`endif
);
    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int DEPTH     = (VECTOR_LENGTH + NUM_BANKS - 1) / NUM_BANKS;
    localparam int WORD_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LANE_W    = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int BANK_W    = (NUM_BANKS > 1) ? BANK_BITS : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                  r_state, w_state_next;
    logic                    r_write;
    logic [ADDR_WIDTH-1:0]   r_addr  [PORTS];
    logic [DATA_WIDTH-1:0]   r_wdata [PORTS];
    logic [DATA_WIDTH-1:0]   r_rdata [PORTS];
    logic [PORTS-1:0]        r_pending;
    logic [PORTS-1:0]        r_err;
    logic                    r_rsp_valid;
    logic [LANE_W-1:0]       r_ptr     [NUM_BANKS];
    logic                    r_cap_valid [NUM_BANKS];
    logic [LANE_W-1:0]       r_cap_lane  [NUM_BANKS];

    logic                    w_accept;
    logic [PORTS-1:0]        w_in_range;
    logic [BANK_W-1:0]       w_lane_bank [PORTS];
    logic [WORD_W-1:0]       w_lane_word [PORTS];
    logic                    w_gnt_valid [NUM_BANKS];
    logic [LANE_W-1:0]       w_gnt_lane  [NUM_BANKS];
    logic [DATA_WIDTH-1:0]   w_bank_rdata [NUM_BANKS];
    logic [PORTS-1:0]        w_gnt_mask;

    assign w_accept = (r_state == S_IDLE) && bus.req_valid;

    generate
        for (genvar gi = 0; gi < PORTS; gi++) begin : g_lane
            assign w_in_range[gi]  = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH] < ADDR_WIDTH'(VECTOR_LENGTH);
            assign w_lane_bank[gi] = BANK_W'(r_addr[gi] % NUM_BANKS);
            assign w_lane_word[gi] = WORD_W'(r_addr[gi] >> BANK_BITS);
            assign bus.rsp_rdata[gi*DATA_WIDTH +: DATA_WIDTH] = r_rdata[gi];
        end

        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            logic                  l_valid;
            logic [LANE_W-1:0]     l_lane;
            logic [LANE_W-1:0]     l_idx;
            int                    l_sum;
            logic [DATA_WIDTH-1:0] r_mem [DEPTH];
            logic [DATA_WIDTH-1:0] r_q;

            // Scan lanes starting at this bank's pointer; the first pending hit wins.
            always_comb begin
                l_valid = 1'b0;
                l_lane  = '0;
                l_idx   = '0;
                l_sum   = 0;
                for (int k = 0; k < PORTS; k++) begin
                    l_sum = int'(r_ptr[gi]) + k;
                    if (l_sum >= PORTS) l_sum = l_sum - PORTS;
                    l_idx = LANE_W'(l_sum);
                    if (!l_valid && r_pending[l_idx] && (w_lane_bank[l_idx] == BANK_W'(gi))) begin
                        l_valid = 1'b1;
                        l_lane  = l_idx;
                    end
                end
                if (r_state != S_ISSUE) l_valid = 1'b0;
            end

            always_ff @(posedge clk) begin
                if (l_valid) begin
                    if (r_write) r_mem[w_lane_word[l_lane]] <= r_wdata[l_lane];
                    r_q <= r_mem[w_lane_word[l_lane]];
                end
            end

            assign w_gnt_valid[gi]  = l_valid;
            assign w_gnt_lane[gi]   = l_lane;
            assign w_bank_rdata[gi] = r_q;
        end
    endgenerate

    always_comb begin
        w_gnt_mask = '0;
        for (int b = 0; b < NUM_BANKS; b++)
            if (w_gnt_valid[b]) w_gnt_mask[w_gnt_lane[b]] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.req_valid) w_state_next = S_ISSUE;
            S_ISSUE: if ((r_pending & ~w_gnt_mask) == '0) w_state_next = S_WAIT;
            S_WAIT:  w_state_next = S_RESP;
            S_RESP:  if (r_rsp_valid && bus.rsp_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (r_state == S_IDLE);
        bus.rsp_valid = r_rsp_valid;
        bus.rsp_err   = r_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write     <= 1'b0;
            r_pending   <= '0;
            r_err       <= '0;
            r_rsp_valid <= 1'b0;
            for (int i = 0; i < PORTS; i++) begin
                r_addr[i]  <= '0;
                r_wdata[i] <= '0;
                r_rdata[i] <= '0;
            end
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_ptr[b]       <= '0;
                r_cap_valid[b] <= 1'b0;
                r_cap_lane[b]  <= '0;
            end
        end else begin
            // rsp_valid rises one cycle into RESP and drops on the handshake edge.
            r_rsp_valid <= (r_state == S_RESP) && !(r_rsp_valid && bus.rsp_ready);
            if (w_accept) begin
                r_write   <= bus.req_write;
                r_pending <= bus.req_mask & w_in_range;
                r_err     <= bus.req_mask & ~w_in_range;
                for (int i = 0; i < PORTS; i++) begin
                    r_addr[i]  <= bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    r_wdata[i] <= bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                    r_rdata[i] <= '0;
                end
            end else begin
                r_pending <= r_pending & ~w_gnt_mask;
            end
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_cap_valid[b] <= w_gnt_valid[b] && !r_write;
                r_cap_lane[b]  <= w_gnt_lane[b];
                if (w_gnt_valid[b])
                    r_ptr[b] <= (w_gnt_lane[b] == LANE_W'(PORTS - 1)) ? '0 : w_gnt_lane[b] + 1'b1;
                if (r_cap_valid[b]) r_rdata[r_cap_lane[b]] <= w_bank_rdata[b];
            end
        end
    end

`ifdef BANKED_VRAM_STATS_EN
    logic r_first_issue;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_conflict_cycles <= '0;
            stat_requests        <= '0;
            r_first_issue        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_first_issue <= 1'b1;
                if (stat_requests != 32'hFFFF_FFFF) stat_requests <= stat_requests + 1'b1;
            end else if (r_state == S_ISSUE) begin
                r_first_issue <= 1'b0;
                if (!r_first_issue && stat_conflict_cycles != 32'hFFFF_FFFF)
                    stat_conflict_cycles <= stat_conflict_cycles + 1'b1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_banked_vector_ram.sv
// Directed plus random bench for banked_vector_ram against a lane/bank model
// built from ranked round-robin order and a flat element memory.
module tb_banked_vector_ram;
    localparam int P  = 8;
    localparam int NB = 4;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int VL = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    banked_vector_ram_if #(.PORTS(P), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

`ifdef BANKED_VRAM_STATS_EN
    logic [31:0] stat_conflict_cycles;
    logic [31:0] stat_requests;
`endif

    banked_vector_ram #(
        .PORTS(P), .NUM_BANKS(NB), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .VECTOR_LENGTH(VL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
`ifdef BANKED_VRAM_STATS_EN
        ,
        .stat_conflict_cycles (stat_conflict_cycles),
        .stat_requests        (stat_requests)
`endif
    );

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    int txn      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] mem_m [VL];
    int            ptr_m [NB];

    logic          t_write;
    logic [P-1:0]  t_mask;
    logic [AW-1:0] t_addr  [P];
    logic [DW-1:0] t_wdata [P];
    logic [DW-1:0] exp_rdata [P];
    logic [P-1:0]  exp_err;
    int            exp_n;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Each lane's grant position in its bank is its distance past the bank pointer.
    task automatic model_request();
        logic [P-1:0] pend;
        int bank [P];
        int rank [P];
        int cnt  [NB];
        int best [NB];
        bit win;
        for (int b = 0; b < NB; b++) begin cnt[b] = 0; best[b] = -1; end
        for (int i = 0; i < P; i++) begin
            pend[i]      = t_mask[i] && (int'(t_addr[i]) < VL);
            exp_err[i]   = t_mask[i] && !(int'(t_addr[i]) < VL);
            bank[i]      = int'(t_addr[i]) % NB;
            rank[i]      = (i - ptr_m[bank[i]] + P) % P;
            exp_rdata[i] = (!t_write && pend[i]) ? mem_m[t_addr[i]] : '0;
            if (pend[i]) begin
                cnt[bank[i]]++;
                if (best[bank[i]] < 0 || rank[i] > rank[best[bank[i]]]) best[bank[i]] = i;
            end
        end
        exp_n = 1;
        for (int b = 0; b < NB; b++) if (cnt[b] > exp_n) exp_n = cnt[b];
        if (t_write) begin
            for (int i = 0; i < P; i++) begin
                if (!pend[i]) continue;
                win = 1'b1;
                for (int j = 0; j < P; j++)
                    if (pend[j] && t_addr[j] == t_addr[i] && rank[j] > rank[i]) win = 1'b0;
                if (win) mem_m[t_addr[i]] = t_wdata[i];
            end
        end
        for (int b = 0; b < NB; b++) if (best[b] >= 0) ptr_m[b] = (best[b] + 1) % P;
    endtask

    task automatic check_rsp(input string ph);
        for (int i = 0; i < P; i++)
            check($sformatf("%s rdata[%0d]", ph, i), bus.rsp_rdata[i*DW +: DW], exp_rdata[i]);
        check({ph, " rsp_err"}, DW'(bus.rsp_err), DW'(exp_err));
    endtask

    task automatic drive_req();
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = t_write;
        bus.req_mask  = t_mask;
        for (int i = 0; i < P; i++) begin
            bus.req_addr[i*AW +: AW]  = t_addr[i];
            bus.req_wdata[i*DW +: DW] = t_wdata[i];
        end
    endtask

    task automatic run_txn(input int hold);
        int acc;
        int guard;
        model_request();
        drive_req();
        check("req_ready idle", DW'(bus.req_ready), 1);
        @(negedge clk);
        acc = cyc;
        bus.req_valid = 1'b0;
        check("req_ready busy", DW'(bus.req_ready), 0);
        guard = 0;
        while (!bus.rsp_valid && guard < 200) begin @(negedge clk); guard++; end
        check("rsp_valid", DW'(bus.rsp_valid), 1);
        check("latency", DW'(cyc - acc), DW'(exp_n + 2));
        check_rsp("rsp");
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold rsp_valid", DW'(bus.rsp_valid), 1);
            check("hold req_ready", DW'(bus.req_ready), 0);
            check_rsp("hold");
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("post rsp_valid", DW'(bus.rsp_valid), 0);
        check("post req_ready", DW'(bus.req_ready), 1);
        $display("txn %0d op=%s mask=%02h N=%0d latency=%0d hold=%0d", txn,
                 t_write ? "WR" : "RD", t_mask, exp_n, cyc - acc - 1, hold);
        txn++;
    endtask

    task automatic set_all(input logic wr, input logic [P-1:0] m, input int base, input int stride);
        t_write = wr;
        t_mask  = m;
        for (int i = 0; i < P; i++) begin
            t_addr[i]  = AW'(base + i * stride);
            t_wdata[i] = '0;
        end
    endtask

    initial begin
        int acc;
`ifdef BANKED_VRAM_STATS_EN
        logic [31:0] s_conf;
        logic [31:0] s_req;
`endif
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_mask  = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        for (int b = 0; b < NB; b++) ptr_m[b] = 0;
        repeat (3) @(negedge clk);
        check("reset req_ready", DW'(bus.req_ready), 1);
        check("reset rsp_valid", DW'(bus.rsp_valid), 0);
        check("reset rsp_rdata0", bus.rsp_rdata[DW-1:0], 0);
        check("reset rsp_err", DW'(bus.rsp_err), 0);
        rst_n = 1'b1;

        for (int blk = 0; blk < VL / P; blk++) begin
            set_all(1'b1, 8'hFF, blk * P, 1);
            for (int i = 0; i < P; i++) t_wdata[i] = $urandom;
            run_txn(0);
        end

        set_all(1'b1, 8'hFF, 0, 1);
        for (int i = 0; i < P; i++) t_wdata[i] = 100 + i;
        run_txn(0);
        set_all(1'b0, 8'hFF, 0, 1);
        run_txn(0);
        check("seq read lane7", exp_rdata[7], 107);

        set_all(1'b1, 8'h01, 4, 0);
        t_wdata[0] = 32'hA5;
        run_txn(0);
        set_all(1'b0, 8'hFF, 4, 0);
`ifdef BANKED_VRAM_STATS_EN
        s_conf = stat_conflict_cycles;
        s_req  = stat_requests;
`endif
        run_txn(0);
`ifdef BANKED_VRAM_STATS_EN
        check("stat conflict delta", stat_conflict_cycles - s_conf, 7);
        check("stat requests delta", stat_requests - s_req, 1);
`endif

        set_all(1'b0, 8'b0000_0101, 0, 0);
        t_addr[0] = 1;
        t_addr[2] = 70;
        run_txn(0);

        set_all(1'b0, 8'h07, 1, 0);
        run_txn(5);

        set_all(1'b0, 8'hFF, 4, 0);
        drive_req();
        @(negedge clk);
        bus.req_valid = 1'b0;
        acc = cyc;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset req_ready", DW'(bus.req_ready), 1);
        check("midreset rsp_valid", DW'(bus.rsp_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int b = 0; b < NB; b++) ptr_m[b] = 0;
        repeat (12) @(negedge clk);
        check("no rsp after reset", DW'(bus.rsp_valid), 0);
        $display("txn %0d mid-ISSUE reset after %0d cycles", txn, cyc - acc);
        txn++;

        set_all(1'b1, 8'b0010_1000, 8, 0);
        t_wdata[3] = 32'h11;
        t_wdata[5] = 32'h22;
        run_txn(0);
        set_all(1'b0, 8'h01, 8, 0);
        run_txn(0);
        check("ww ptr0 winner", bus.rsp_rdata[DW-1:0], 32'h22);
        set_all(1'b0, 8'b0000_1000, 0, 0);
        run_txn(0);
        set_all(1'b1, 8'b0010_1000, 8, 0);
        t_wdata[3] = 32'h11;
        t_wdata[5] = 32'h22;
        run_txn(0);
        set_all(1'b0, 8'h01, 8, 0);
        run_txn(0);
        check("ww ptr4 winner", bus.rsp_rdata[DW-1:0], 32'h11);

        for (int it = 0; it < 40; it++) begin
            t_write = 1'($urandom_range(0, 1));
            t_mask  = P'($urandom);
            for (int i = 0; i < P; i++) begin
                t_addr[i]  = AW'($urandom_range(0, (it % 3 == 0) ? 11 : 79));
                t_wdata[i] = $urandom;
            end
            run_txn($urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
